// File: rtl/ram_porta_arbiter.sv
// ---------------------------------------------------------------------------
// ram_porta_arbiter
//
// Shares port A of the 2048x8 dual-port station RAM between two requesters:
//   requester 0 - communication frame engine
//   requester 1 - control / diagnostic logic
// Single-byte accesses are serialised with round-robin priority. The RAM
// A-side address, data and write enable come straight from registers, and
// read data is steered back to whichever requester issued the read.
//
// Handshake (REQx / GNTx): a requester raises REQx with WRx/ADDRx/WDATAx
// valid and holds all of them until it sees GNTx=1 in the same cycle. The
// access is accepted on the clock edge that ends a GNTx cycle. After that
// edge the requester may drop REQx or present its next access. Dropping REQx
// without a grant abandons the access; nothing reaches the RAM.
//
// Ports:
//   CLK, RST_N             clock (also RAM A_CLK), async active-low reset
//   REQx, WRx              request, 1 = write / 0 = read
//   ADDRx, WDATAx          byte address and write data
//   GNTx                   combinational grant (depends on REQ0/REQ1/pointer)
//   RVALIDx                registered, RDATA belongs to requester x this cycle
//   RDATA                  shared read data, equal to RAM_DOUT
//   RAM_ADDR/DIN/WEN       registered drive into RAM port A
//   RAM_DOUT               RAM port A data out (registered inside wrapper)
//   BUSY                   registered, a RAM cycle or read is in progress
// ---------------------------------------------------------------------------
module ram_porta_arbiter #(
    parameter int AW     = 11,
    parameter int DW     = 8,
    parameter int RD_LAT = 3
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          WR0,
    input  logic          WR1,
    input  logic [AW-1:0] ADDR0,
    input  logic [AW-1:0] ADDR1,
    input  logic [DW-1:0] WDATA0,
    input  logic [DW-1:0] WDATA1,
    output logic          GNT0,
    output logic          GNT1,
    output logic          RVALID0,
    output logic          RVALID1,
    output logic [DW-1:0] RDATA,
    output logic [AW-1:0] RAM_ADDR,
    output logic [DW-1:0] RAM_DIN,
    output logic          RAM_WEN,
    input  logic [DW-1:0] RAM_DOUT,
    output logic          BUSY
);

    // Round-robin pointer: 0 = requester 0 wins a contested cycle.
    logic              ptr_q, ptr_d;
    logic [AW-1:0]     ram_addr_q, ram_addr_d;
    logic [DW-1:0]     ram_din_q, ram_din_d;
    logic              ram_wen_q, ram_wen_d;
    // Read-tag pipeline, one-hot per requester: tagN_q[k] set means a read
    // for requester N was granted k+1 cycles ago. Stage 0 doubles as the
    // registered "read issued" flag.
    logic [RD_LAT-1:0] tag0_q, tag0_d;
    logic [RD_LAT-1:0] tag1_q, tag1_d;
    logic              busy_q, busy_d;

    logic              gnt0, gnt1;
    logic              rd_push0, rd_push1;

    // Grant: a pure function of REQ0, REQ1 and the pointer. Gated by RST_N so
    // nothing is granted while reset is held.
    always_comb begin
        gnt0 = RST_N & REQ0 & (~REQ1 | ~ptr_q);
        gnt1 = RST_N & REQ1 & (~REQ0 |  ptr_q);
    end

    // Next-state logic for all registers.
    always_comb begin
        ptr_d      = ptr_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_wen_d  = 1'b0;
        rd_push0   = 1'b0;
        rd_push1   = 1'b0;

        if (gnt0) begin
            ptr_d      = 1'b1;
            ram_addr_d = ADDR0;
            ram_din_d  = WDATA0;
            ram_wen_d  = WR0;
            rd_push0   = ~WR0;
        end else if (gnt1) begin
            ptr_d      = 1'b0;
            ram_addr_d = ADDR1;
            ram_din_d  = WDATA1;
            ram_wen_d  = WR1;
            rd_push1   = ~WR1;
        end

        tag0_d = {tag0_q[RD_LAT-2:0], rd_push0};
        tag1_d = {tag1_q[RD_LAT-2:0], rd_push1};

        // BUSY is registered from next-state values so it lines up with the
        // RAM_WEN cycle and with every cycle a read tag is still in flight.
        busy_d = ram_wen_d | (|tag0_d) | (|tag1_d);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q      <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_wen_q  <= 1'b0;
            tag0_q     <= '0;
            tag1_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_wen_q  <= ram_wen_d;
            tag0_q     <= tag0_d;
            tag1_q     <= tag1_d;
            busy_q     <= busy_d;
        end
    end

    // The last tag stage lines up with RAM_DOUT for the same access:
    // 1 cycle in RAM_ADDR register + 2 cycles in RAM and wrapper register.
    always_comb begin
        GNT0     = gnt0;
        GNT1     = gnt1;
        RVALID0  = tag0_q[RD_LAT-1];
        RVALID1  = tag1_q[RD_LAT-1];
        RDATA    = RAM_DOUT;
        RAM_ADDR = ram_addr_q;
        RAM_DIN  = ram_din_q;
        RAM_WEN  = ram_wen_q;
        BUSY     = busy_q;
    end

endmodule
